// File: rtl/ir_period_classifier.sv
// rtl/ir_period_classifier.sv - IR beacon period measurement and frequency classification
module ir_period_classifier #(
  parameter int CLK_HZ   = 100000000,
  parameter int CNT_W    = 20,
  parameter int TIMEOUT  = 1000000,
  parameter int P200_MIN = 450000,
  parameter int P200_MAX = 550000,
  parameter int P1K_MIN  = 90000,
  parameter int P1K_MAX  = 110000,
  parameter int P5K_MIN  = 18000,
  parameter int P5K_MAX  = 22000,
  parameter int P7K_MIN  = 13000,
  parameter int P7K_MAX  = 15500
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blinky,
  output logic [CNT_W-1:0] clk_count,
  output logic             done,
  output logic [2:0]       decision
);

  // Refuse to elaborate with a clock rate that makes the windows meaningless
  // or a timeout the counter cannot reach without wrapping.
  if (CLK_HZ <= 0 || TIMEOUT <= 0 || TIMEOUT >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("ir_period_classifier: invalid CLK_HZ/TIMEOUT/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] clk_count_q, clk_count_d;
  logic             done_q, done_d;
  logic [2:0]       decision_q, decision_d;
  logic             rise;

  // Map a measured period onto a beacon code; windows are inclusive and
  // disjoint, anything outside all of them is reported as unknown.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] c);
    logic [2:0] code;
    code = 3'd0;
    if (c >= CNT_W'(P200_MIN) && c <= CNT_W'(P200_MAX)) code = 3'd1;
    else if (c >= CNT_W'(P1K_MIN) && c <= CNT_W'(P1K_MAX)) code = 3'd2;
    else if (c >= CNT_W'(P5K_MIN) && c <= CNT_W'(P5K_MAX)) code = 3'd3;
    else if (c >= CNT_W'(P7K_MIN) && c <= CNT_W'(P7K_MAX)) code = 3'd4;
    return code;
  endfunction

  // Next-state logic: synchroniser, edge detect, period counter and result capture.
  always_comb begin
    s1_d        = blinky;
    s2_d        = s1_q;
    prev_d      = s2_q;
    rise        = s2_q & ~prev_q;
    state_d     = state_q;
    count_d     = count_q;
    clk_count_d = clk_count_q;
    decision_d  = decision_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // First edge only opens a measurement; its period is partial.
        if (rise) begin
          state_d = MEASURE;
          count_d = ONE_C;
        end
      end
      MEASURE: begin
        if (rise) begin
          clk_count_d = count_q;
          decision_d  = classify(count_q);
          done_d      = 1'b1;
          count_d     = ONE_C;
        end else if (count_q == TIMEOUT_C) begin
          // Signal lost: report it once and wait for a fresh first edge.
          clk_count_d = TIMEOUT_C;
          decision_d  = 3'd0;
          done_d      = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end else begin
          count_d = count_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      count_q     <= '0;
      clk_count_q <= '0;
      done_q      <= 1'b0;
      decision_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      prev_q      <= prev_d;
      count_q     <= count_d;
      clk_count_q <= clk_count_d;
      done_q      <= done_d;
      decision_q  <= decision_d;
    end
  end

  assign clk_count = clk_count_q;
  assign done      = done_q;
  assign decision  = decision_q;

endmodule

// File: tb/tb_ir_period_classifier.sv
// tb/tb_ir_period_classifier.sv - self-checking bench for ir_period_classifier
module tb_ir_period_classifier;

  // Periods scaled down by 100 so the whole run stays short.
  localparam int CNT_W    = 20;
  localparam int TIMEOUT  = 10000;
  localparam int P200_MIN = 4500;
  localparam int P200_MAX = 5500;
  localparam int P1K_MIN  = 900;
  localparam int P1K_MAX  = 1100;
  localparam int P5K_MIN  = 180;
  localparam int P5K_MAX  = 220;
  localparam int P7K_MIN  = 130;
  localparam int P7K_MAX  = 155;

  logic             clock = 1'b0;
  logic             reset;
  logic             blinky;
  logic [CNT_W-1:0] clk_count;
  logic             done;
  logic [2:0]       decision;

  ir_period_classifier #(
    .CLK_HZ(100000000), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
    .P200_MIN(P200_MIN), .P200_MAX(P200_MAX), .P1K_MIN(P1K_MIN), .P1K_MAX(P1K_MAX),
    .P5K_MIN(P5K_MIN), .P5K_MAX(P5K_MAX), .P7K_MIN(P7K_MIN), .P7K_MAX(P7K_MAX)
  ) dut (
    .clock(clock), .reset(reset), .blinky(blinky),
    .clk_count(clk_count), .done(done), .decision(decision)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int dec;
    int cnt;
    int at;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  prev_done = 1'b0;
  bit  wide_seen = 1'b0;

  // Observe every done pulse away from the active edge.
  always @(negedge clock) begin
    if (done === 1'b1) got_q.push_back('{int'(decision), int'(clk_count), cyc});
    if (done === 1'b1 && prev_done) wide_seen = 1'b1;
    prev_done = (done === 1'b1);
  end

  // Reference model: works purely from the times at which blinky rises.
  bit lvl       = 1'b0;
  bit locked    = 1'b0;
  int last_rise = 0;

  function automatic int classify(int p);
    if (p >= P200_MIN && p <= P200_MAX) return 1;
    if (p >= P1K_MIN && p <= P1K_MAX) return 2;
    if (p >= P5K_MIN && p <= P5K_MAX) return 3;
    if (p >= P7K_MIN && p <= P7K_MAX) return 4;
    return 0;
  endfunction

  // A rise driven when k clock edges have passed is detected two edges later
  // and reported one edge after that.
  task automatic model_rise(int k);
    int gap;
    if (locked) begin
      gap = k - last_rise;
      if (gap <= TIMEOUT) exp_q.push_back('{classify(gap), gap, k + 3});
      else exp_q.push_back('{0, TIMEOUT, last_rise + 3 + TIMEOUT});
    end
    locked    = 1'b1;
    last_rise = k;
  endtask

  task automatic set_level(bit v);
    @(negedge clock);
    blinky = v;
    if (v && !lvl) model_rise(cyc);
    lvl = v;
  endtask

  task automatic square(int p);
    set_level(1'b1);
    repeat (p / 2 - 1) @(negedge clock);
    set_level(1'b0);
    repeat (p - p / 2 - 1) @(negedge clock);
  endtask

  task automatic check(string tag, int obs, int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic flush(string tag);
    int n;
    repeat (4) @(negedge clock);
    check($sformatf("%s pulses", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d] decision", tag, i), got_q[i].dec, exp_q[i].dec);
      check($sformatf("%s[%0d] clk_count", tag, i), got_q[i].cnt, exp_q[i].cnt);
      check($sformatf("%s[%0d] cycle", tag, i), got_q[i].at, exp_q[i].at);
    end
    if (exp_q.size() > 0) begin
      check($sformatf("%s held decision", tag), int'(decision), exp_q[$].dec);
      check($sformatf("%s held clk_count", tag), int'(clk_count), exp_q[$].cnt);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int kind;
    reset  = 1'b1;
    blinky = 1'b0;
    repeat (3) @(negedge clock);
    check("reset done", int'(done), 0);
    check("reset decision", int'(decision), 0);
    check("reset clk_count", int'(clk_count), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 1 kHz lock: first edge silent, then one pulse per period.
    repeat (5) square(1000);
    flush("1k");

    repeat (3) square(5000);
    flush("200hz");
    repeat (3) square(200);
    flush("5k");
    repeat (3) square(143);
    flush("7k");

    // Window edges; each rise closes the previous square's period.
    square(130); square(129); square(155); square(156); square(300); square(130);
    flush("bounds");

    // Timeout after a lock, then re-acquire.
    repeat (2) square(1000);
    flush("pre_to");
    repeat (TIMEOUT + 100) @(negedge clock);
    repeat (2) square(1000);
    flush("timeout");

    // Reset in the low half of a 5 kHz period.
    repeat (3) square(200);
    flush("pre_rst");
    set_level(1'b1);
    repeat (99) @(negedge clock);
    set_level(1'b0);
    repeat (30) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async rst done", int'(done), 0);
    check("async rst decision", int'(decision), 0);
    check("async rst clk_count", int'(clk_count), 0);
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    locked = 1'b0;
    repeat (60) @(negedge clock);
    repeat (2) square(200);
    flush("post_rst");

    // Random mix of in-window and out-of-window periods.
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0:       p = $urandom_range(P1K_MIN, P1K_MAX);
        1:       p = $urandom_range(P5K_MIN, P5K_MAX);
        2:       p = $urandom_range(P7K_MIN, P7K_MAX);
        3:       p = $urandom_range(6, P7K_MIN - 1);
        default: p = $urandom_range(P5K_MAX + 1, P1K_MIN - 1);
      endcase
      square(p);
    end
    square(200);
    flush("random");

    check("done one cycle wide", int'(wide_seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
